// File: rtl/pipelined_adder.sv
// pipelined_adder: pipelined add/subtract unit with a valid/ready handshake.
// The BUS_SIZE-bit carry chain is cut into STAGES registered slices of width
// W = BUS_SIZE/STAGES. Each item carries its not-yet-summed upper operand bits
// and its already-summed lower result bits down the pipe.
// Flags (carry, overflow, zero) are produced in the last slice.
// Optional feature macro: ADDER_SATURATION_EN. When it is defined, op[1]=1
// clamps an overflowing result to the signed maximum or minimum. When it is
// undefined, op[1] is ignored.
module pipelined_adder #(
  parameter int BUS_SIZE = 32,
  parameter int STAGES   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUS_SIZE-1:0] a,
  input  logic [BUS_SIZE-1:0] b,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUS_SIZE-1:0] sum,
  output logic                carry,
  output logic                overflow,
  output logic                zero
);

  localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int W           = BUS_SIZE / STAGES_SAFE;

  if (STAGES < 1 || (BUS_SIZE % STAGES_SAFE) != 0) begin : g_param_check
    $error("pipelined_adder: STAGES must be >= 1 and divide BUS_SIZE");
  end

  // The whole pipe advances together. A stalled result freezes every stage.
  logic en_s;
  assign en_s     = !out_valid || out_ready;
  assign in_ready = reset && en_s;

`ifdef ADDER_SATURATION_EN
  logic sat_req_s;
  assign sat_req_s = op[1];
`else
  logic unused_op_s;
  assign unused_op_s = op[1];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still to be summed. Bit 0 here is bit k*W of the bus.
    localparam int UW = BUS_SIZE - k*W;

    logic [UW-1:0]      a_s;
    logic [UW-1:0]      b_s;
    logic               c_s;
    logic               v_s;
    logic [(k+1)*W-1:0] ps_s;
    logic [W:0]         add_s;
`ifdef ADDER_SATURATION_EN
    logic               q_s;
`endif

    assign add_s = {1'b0, a_s[W-1:0]} + {1'b0, b_s[W-1:0]} + {{W{1'b0}}, c_s};

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1. The +1 enters as the carry into the first slice.
      assign a_s  = a;
      assign b_s  = op[0] ? ~b : b;
      assign c_s  = op[0];
      assign v_s  = in_valid && in_ready;
      assign ps_s = add_s[W-1:0];
`ifdef ADDER_SATURATION_EN
      assign q_s  = sat_req_s;
`endif
    end else begin : g_src
      assign a_s  = g_st[k-1].g_reg.a_r;
      assign b_s  = g_st[k-1].g_reg.b_r;
      assign c_s  = g_st[k-1].g_reg.c_r;
      assign v_s  = g_st[k-1].g_reg.v_r;
      assign ps_s = {add_s[W-1:0], g_st[k-1].g_reg.lo_r};
`ifdef ADDER_SATURATION_EN
      assign q_s  = g_st[k-1].g_reg.q_r;
`endif
    end

    if (k < STAGES-1) begin : g_reg
      logic [UW-W-1:0]    a_r;
      logic [UW-W-1:0]    b_r;
      logic [(k+1)*W-1:0] lo_r;
      logic               c_r;
      logic               v_r;
`ifdef ADDER_SATURATION_EN
      logic               q_r;
`endif

      // Slice register: forwards the slice carry, the partial result and the upper operands.
      always_ff @(posedge clk) begin
        if (!reset) begin
          v_r  <= 1'b0;
          c_r  <= 1'b0;
          a_r  <= {(UW-W){1'b0}};
          b_r  <= {(UW-W){1'b0}};
          lo_r <= {((k+1)*W){1'b0}};
`ifdef ADDER_SATURATION_EN
          q_r  <= 1'b0;
`endif
        end else if (en_s) begin
          v_r  <= v_s;
          c_r  <= add_s[W];
          a_r  <= a_s[UW-1:W];
          b_r  <= b_s[UW-1:W];
          lo_r <= ps_s;
`ifdef ADDER_SATURATION_EN
          q_r  <= q_s;
`endif
        end
      end
    end else begin : g_out
      // In the last slice, a_s and b_s hold only the top W bits, so [W-1] is the bus MSB.
      logic                ov_s;
      logic [BUS_SIZE-1:0] fin_s;

      assign ov_s = (a_s[W-1] == b_s[W-1]) && (ps_s[BUS_SIZE-1] != a_s[W-1]);

`ifdef ADDER_SATURATION_EN
      // Clamp to the signed limit on the side the operands point to. Carry stays unclamped.
      always_comb begin
        fin_s = ps_s;
        if (q_s && ov_s) begin
          if (a_s[W-1]) begin
            fin_s = {1'b1, {(BUS_SIZE-1){1'b0}}};
          end else begin
            fin_s = {1'b0, {(BUS_SIZE-1){1'b1}}};
          end
        end else begin
          fin_s = ps_s;
        end
      end
`else
      assign fin_s = ps_s;
`endif

      // Output register. Result and flags change only when a real item arrives.
      always_ff @(posedge clk) begin
        if (!reset) begin
          out_valid <= 1'b0;
          sum       <= {BUS_SIZE{1'b0}};
          carry     <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (en_s) begin
          out_valid <= v_s;
          if (v_s) begin
            sum      <= fin_s;
            carry    <= add_s[W];
            overflow <= ov_s;
            zero     <= (fin_s == {BUS_SIZE{1'b0}});
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder.
// The bench drives a 4-stage instance and a 1-stage instance.
// Expected values are computed by hand for each vector.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, carry, overflow, zero;
  logic [31:0] a, b, sum;
  logic [1:0]  op;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, carry1, overflow1, zero1;
  logic [31:0] a1, b1, sum1;
  logic [1:0]  op1;

  int nvec = 0;
  int nerr = 0;

  pipelined_adder #(.BUS_SIZE(32), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
  );

  pipelined_adder #(.BUS_SIZE(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry(carry1), .overflow(overflow1), .zero(zero1)
  );

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0; op = 2'b00; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = 32'h0; b1 = 32'h0; op1 = 2'b00; out_ready1 = 1'b1;
    @(posedge clk); #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready2: got %b want 0", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    nvec++; if (sum !== 32'h0) begin nerr++; $display("FAIL rst_sum: got %h want 0", sum); end
    nvec++; if ({carry, overflow, zero} !== 3'b000) begin nerr++; $display("FAIL rst_flags: got %b want 000", {carry, overflow, zero}); end
    nvec++; if (out_valid1 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid1: got %b want 0", out_valid1); end
    reset = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    nvec++; if (in_ready1 !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready1: got %b want 1", in_ready1); end
  endtask

  task automatic test_cross_carry();
    in_valid = 1'b1; a = 32'h0000FFFF; b = 32'h00000001; op = 2'b00;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (e < 4) begin
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL lat_early e%0d: got %b want 0", e, out_valid); end
      end else begin
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL lat_valid: got %b want 1", out_valid); end
        nvec++; if (sum !== 32'h00010000) begin nerr++; $display("FAIL xcarry_sum: got %h want 00010000", sum); end
        nvec++; if ({carry, overflow, zero} !== 3'b000) begin nerr++; $display("FAIL xcarry_flags: got %b want 000", {carry, overflow, zero}); end
      end
    end
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL xcarry_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] es [4];
    logic [1:0]  vo [4];
    logic [2:0]  ef [4];
    int got, first, last;
    va = '{32'hFFFFFFFF, 32'd2, 32'd5, 32'h7FFFFFFF};
    vb = '{32'd1, 32'd3, 32'd5, 32'd1};
    vo = '{2'b00, 2'b00, 2'b01, 2'b00};
    es = '{32'h0, 32'd5, 32'h0, 32'h80000000};
    ef = '{3'b101, 3'b000, 3'b101, 3'b010};
    got = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; a = va[i]; b = vb[i]; op = vo[i];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        if (got < 4) begin
          nvec++; if (sum !== es[got]) begin nerr++; $display("FAIL b2b_sum%0d: got %h want %h", got, sum, es[got]); end
          nvec++; if ({carry, overflow, zero} !== ef[got]) begin nerr++; $display("FAIL b2b_flags%0d: got %b want %b", got, {carry, overflow, zero}, ef[got]); end
        end else begin
          nvec++; nerr++; $display("FAIL b2b_extra: got result %h want none", sum);
        end
        if (first < 0) first = i;
        last = i;
        got++;
      end
    end
    nvec++; if (got !== 4) begin nerr++; $display("FAIL b2b_count: got %0d want 4", got); end
    nvec++; if (first !== 3 || last !== 6) begin nerr++; $display("FAIL b2b_timing: got %0d..%0d want 3..6", first, last); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_sum;
`ifdef ADDER_SATURATION_EN
    exp_sum = 32'h80000000;
`else
    exp_sum = 32'h7FFFFFFF;
`endif
    in_valid = 1'b1; a = 32'h80000000; b = 32'h00000001; op = 2'b11;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL sat_valid: got %b want 1", out_valid); end
    nvec++; if (sum !== exp_sum) begin nerr++; $display("FAIL sat_sum: got %h want %h", sum, exp_sum); end
    nvec++; if ({carry, overflow, zero} !== 3'b110) begin nerr++; $display("FAIL sat_flags: got %b want 110", {carry, overflow, zero}); end
    op = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] es [4];
    logic [1:0]  vo [4];
    logic [2:0]  ef [4];
    va = '{32'd1, 32'd10, 32'd100, 32'h12345678};
    vb = '{32'd1, 32'd20, 32'd1, 32'h11111111};
    vo = '{2'b00, 2'b00, 2'b01, 2'b00};
    es = '{32'd2, 32'd30, 32'd99, 32'h23456789};
    ef = '{3'b000, 3'b000, 3'b100, 3'b000};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; op = vo[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    nvec++; if (out_valid !== 1'b1 || sum !== es[0]) begin nerr++; $display("FAIL stall_head: got v=%b %h want v=1 %h", out_valid, sum, es[0]); end
    for (int s = 0; s < 3; s++) begin
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready%0d: got %b want 0", s, in_ready); end
      @(posedge clk); #1;
      nvec++; if (out_valid !== 1'b1 || sum !== es[0]) begin nerr++; $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", s, out_valid, sum, es[0]); end
      nvec++; if ({carry, overflow, zero} !== ef[0]) begin nerr++; $display("FAIL stall_flags%0d: got %b want %b", s, {carry, overflow, zero}, ef[0]); end
    end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(posedge clk); #1;
      nvec++; if (out_valid !== 1'b1 || sum !== es[j]) begin nerr++; $display("FAIL stall_drain%0d: got v=%b %h want v=1 %h", j, out_valid, sum, es[j]); end
      nvec++; if ({carry, overflow, zero} !== ef[j]) begin nerr++; $display("FAIL stall_dflags%0d: got %b want %b", j, {carry, overflow, zero}, ef[j]); end
    end
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL stall_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_flush();
    in_valid = 1'b1; a = 32'd7; b = 32'd8; op = 2'b00;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_c%0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_single_stage();
    in_valid1 = 1'b1; a1 = 32'h0000FFFF; b1 = 32'h00000001; op1 = 2'b00;
    @(posedge clk); #1;
    nvec++; if (out_valid1 !== 1'b1 || sum1 !== 32'h00010000) begin nerr++; $display("FAIL s1_first: got v=%b %h want v=1 00010000", out_valid1, sum1); end
    nvec++; if ({carry1, overflow1, zero1} !== 3'b000) begin nerr++; $display("FAIL s1_flags: got %b want 000", {carry1, overflow1, zero1}); end
    a1 = 32'd2; b1 = 32'd3;
    @(posedge clk); #1;
    nvec++; if (out_valid1 !== 1'b1 || sum1 !== 32'd5) begin nerr++; $display("FAIL s1_add: got v=%b %h want v=1 5", out_valid1, sum1); end
    a1 = 32'd5; b1 = 32'd5; op1 = 2'b01;
    @(posedge clk); #1;
    nvec++; if (sum1 !== 32'h0 || {carry1, overflow1, zero1} !== 3'b101) begin nerr++; $display("FAIL s1_sub: got %h %b want 0 101", sum1, {carry1, overflow1, zero1}); end
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    nvec++; if (out_valid1 !== 1'b0) begin nerr++; $display("FAIL s1_idle: got %b want 0", out_valid1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cross_carry();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_reset_flush();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
